bpu_pht: RTL and testbench

Gshare pattern history table for the IFU branch predictor.
- Holds one 2-bit saturating counter per entry, plus a speculative global history register (GHR).
- Serves one prediction lookup per cycle to fetch, and accepts one resolved-branch update per cycle from execute.
- Applies the 2-bit counter transition internally, in the update stage.

---
 rtl/bpu_pht.sv | 121 ++++++++++++
 tb/tb_bpu_pht.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bpu_pht.sv
// Gshare pattern history table with a speculative global history register.
// Serves one lookup per cycle; the response is registered and appears one
// cycle after the request. Accepts one resolved-branch update per cycle.
// An update and a lookup to the same entry in one cycle bypass the updated
// value into the lookup.
module bpu_pht #(
   parameter int PHT_IDX_W = 8,
   parameter int GHR_W     = 8,
   parameter int PC_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pred_valid_i,
   input  logic [PC_W-1:0]      pred_pc_i,
   output logic                 pred_resp_valid_o,
   output logic                 pred_taken_o,
   output logic [1:0]           pred_state_o,
   output logic [PHT_IDX_W-1:0] pred_idx_o,
   output logic [GHR_W-1:0]     pred_ghr_o,
   input  logic                 upd_valid_i,
   input  logic [PHT_IDX_W-1:0] upd_idx_i,
   input  logic                 upd_taken_i,
   input  logic                 upd_mispred_i,
   input  logic [GHR_W-1:0]     upd_ghr_i
);

   localparam int ENTRIES = 1 << PHT_IDX_W;

   logic [1:0]           tbl_q [ENTRIES];
   logic [GHR_W-1:0]     ghr_q, ghr_d;
   logic [PHT_IDX_W-1:0] lk_idx;
   logic [1:0]           upd_new;
   logic [1:0]           lk_state;
   logic [GHR_W-1:0]     ghr_rep;
   logic [GHR_W-1:0]     ghr_spec;

   logic                 resp_vld_q;
   logic [1:0]           resp_state_q;
   logic [PHT_IDX_W-1:0] resp_idx_q;
   logic [GHR_W-1:0]     resp_ghr_q;

   // Only the word-aligned index bits of the PC take part in hashing.
   logic unused_pc;
   assign unused_pc = ^{pred_pc_i[PC_W-1:PHT_IDX_W+2], pred_pc_i[1:0]};

   // 2-bit saturating counter step.
   function automatic logic [1:0] sat_next(input logic [1:0] c, input logic t);
      if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
      else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   assign lk_idx  = pred_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
   assign upd_new = sat_next(tbl_q[upd_idx_i], upd_taken_i);

   // Lookup read, forwarding a same-cycle update to the same entry.
   always_comb begin
      lk_state = tbl_q[lk_idx];
      if (upd_valid_i && (upd_idx_i == lk_idx)) lk_state = upd_new;
   end

   // History shift candidates; a 1-bit history is just the newest outcome.
   generate
      if (GHR_W == 1) begin : g_ghr1
         logic unused_ghr;
         assign unused_ghr = upd_ghr_i[0];
         assign ghr_rep    = upd_taken_i;
         assign ghr_spec   = lk_state[1];
      end else begin : g_ghrn
         logic unused_ghr;
         assign unused_ghr = upd_ghr_i[GHR_W-1];
         assign ghr_rep    = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
         assign ghr_spec   = {ghr_q[GHR_W-2:0], lk_state[1]};
      end
   endgenerate

   // GHR next state: mispredict repair beats speculative shift beats hold.
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid_i && upd_mispred_i) ghr_d = ghr_rep;
      else if (pred_valid_i)            ghr_d = ghr_spec;
   end

   // GHR register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end

   // Counter table: all entries weak-not-taken on reset, one write per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b01;
      end else if (upd_valid_i) begin
         tbl_q[upd_idx_i] <= upd_new;
      end
   end

   // Response register; payload holds when no lookup was made.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_vld_q   <= 1'b0;
         resp_state_q <= 2'b00;
         resp_idx_q   <= '0;
         resp_ghr_q   <= '0;
      end else begin
         resp_vld_q <= pred_valid_i;
         if (pred_valid_i) begin
            resp_state_q <= lk_state;
            resp_idx_q   <= lk_idx;
            resp_ghr_q   <= ghr_q;
         end
      end
   end

   assign pred_resp_valid_o = resp_vld_q;
   assign pred_state_o      = resp_state_q;
   assign pred_taken_o      = resp_state_q[1];
   assign pred_idx_o        = resp_idx_q;
   assign pred_ghr_o        = resp_ghr_q;

endmodule

// File: tb/tb_bpu_pht.sv
// Directed bench for bpu_pht with an expected-response queue.
module tb_bpu_pht;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_valid_i;
   logic [31:0] pred_pc_i;
   logic        pred_resp_valid_o;
   logic        pred_taken_o;
   logic [1:0]  pred_state_o;
   logic [7:0]  pred_idx_o;
   logic [7:0]  pred_ghr_o;
   logic        upd_valid_i;
   logic [7:0]  upd_idx_i;
   logic        upd_taken_i;
   logic        upd_mispred_i;
   logic [7:0]  upd_ghr_i;

   typedef struct {
      logic       v;
      logic [1:0] st;
      logic [7:0] idx;
      logic [7:0] ghr;
   } exp_t;

   exp_t q[$];
   int   npass = 0;
   int   ntotal = 0;

   always #5 clk = ~clk;

   bpu_pht #(.PHT_IDX_W(8), .GHR_W(8), .PC_W(32)) dut (
      .clk(clk), .rst(rst),
      .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
      .pred_resp_valid_o(pred_resp_valid_o), .pred_taken_o(pred_taken_o),
      .pred_state_o(pred_state_o), .pred_idx_o(pred_idx_o), .pred_ghr_o(pred_ghr_o),
      .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
      .upd_mispred_i(upd_mispred_i), .upd_ghr_i(upd_ghr_i)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      ntotal++;
      assert (obs === exp_v) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   // One cycle: drive, queue the expected response, clock, then compare.
   task automatic cyc(input logic pv, input logic [31:0] pc,
                      input logic uv, input logic [7:0] ui, input logic ut,
                      input logic um, input logic [7:0] ug, input exp_t e);
      exp_t got;
      pred_valid_i = pv; pred_pc_i = pc;
      upd_valid_i = uv; upd_idx_i = ui; upd_taken_i = ut;
      upd_mispred_i = um; upd_ghr_i = ug;
      q.push_back(e);
      @(posedge clk); #1;
      pred_valid_i = 1'b0; upd_valid_i = 1'b0; upd_mispred_i = 1'b0;
      got = q.pop_front();
      chk("resp_valid", {7'd0, pred_resp_valid_o}, {7'd0, got.v});
      if (got.v) begin
         chk("state", {6'd0, pred_state_o}, {6'd0, got.st});
         chk("taken", {7'd0, pred_taken_o}, {7'd0, got.st[1]});
         chk("idx",   pred_idx_o, got.idx);
         chk("ghr",   pred_ghr_o, got.ghr);
      end
   endtask

   exp_t none = '{v: 1'b0, st: 2'b00, idx: 8'h00, ghr: 8'h00};

   function automatic exp_t rsp(input logic [1:0] st, input logic [7:0] idx, input logic [7:0] ghr);
      rsp = '{v: 1'b1, st: st, idx: idx, ghr: ghr};
   endfunction

   task automatic look(input logic [31:0] pc, input logic [1:0] st, input logic [7:0] idx, input logic [7:0] ghr);
      cyc(1'b1, pc, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, rsp(st, idx, ghr));
   endtask

   task automatic upd(input logic [7:0] idx, input logic t);
      cyc(1'b0, 32'h0, 1'b1, idx, t, 1'b0, 8'h00, none);
   endtask

   // Lookup with GHR 0 while a mispredict repair to idx 0xFF forces GHR back to 0.
   task automatic probe(input logic [31:0] pc, input logic [1:0] st, input logic [7:0] idx);
      cyc(1'b1, pc, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, rsp(st, idx, 8'h00));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {7'd0, pred_resp_valid_o}, 8'h00);
      chk({tag, "_taken"}, {7'd0, pred_taken_o}, 8'h00);
      chk({tag, "_state"}, {6'd0, pred_state_o}, 8'h00);
      chk({tag, "_idx"},   pred_idx_o, 8'h00);
      chk({tag, "_ghr"},   pred_ghr_o, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      pred_valid_i = 1'b0; pred_pc_i = '0;
      upd_valid_i = 1'b0; upd_idx_i = '0; upd_taken_i = 1'b0;
      upd_mispred_i = 1'b0; upd_ghr_i = '0;
      #3;
      chk_zero("rst0");
      @(posedge clk); #1;
      rst = 1'b0;

      // First lookup and idle gap.
      look(32'h40, 2'b01, 8'h10, 8'h00);
      cyc(1'b0, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, none);

      // Saturate up, then down.
      upd(8'h10, 1'b1); probe(32'h40, 2'b10, 8'h10);
      upd(8'h10, 1'b1); probe(32'h40, 2'b11, 8'h10);
      upd(8'h10, 1'b1); probe(32'h40, 2'b11, 8'h10);
      upd(8'h10, 1'b0); probe(32'h40, 2'b10, 8'h10);
      upd(8'h10, 1'b0); probe(32'h40, 2'b01, 8'h10);
      upd(8'h10, 1'b0); probe(32'h40, 2'b00, 8'h10);
      upd(8'h10, 1'b0); probe(32'h40, 2'b00, 8'h10);

      // Entry to 11, then back-to-back lookups: second one hashes to 0x11.
      upd(8'h10, 1'b1); upd(8'h10, 1'b1); upd(8'h10, 1'b1);
      look(32'h40, 2'b11, 8'h10, 8'h00);
      look(32'h40, 2'b01, 8'h11, 8'h01);

      // Back to entry 01 and GHR 0, then same-cycle lookup/update bypass.
      upd(8'h10, 1'b0); upd(8'h10, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, none);
      cyc(1'b1, 32'h40, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, rsp(2'b10, 8'h10, 8'h00));
      // Bypassed taken was shifted into the GHR.
      look(32'h0, 2'b01, 8'h01, 8'h01);

      // Mispredict repair concurrent with a lookup.
      cyc(1'b1, 32'h40, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h5A, rsp(2'b01, 8'h12, 8'h02));
      look(32'h0, 2'b01, 8'hB5, 8'hB5);

      // Modify an entry, get a valid response in flight, then reset mid-cycle.
      upd(8'h20, 1'b1);
      look(32'h0, 2'b01, 8'h6A, 8'h6A);
      pred_valid_i = 1'b1; pred_pc_i = 32'h80;
      upd_valid_i = 1'b1; upd_idx_i = 8'h20; upd_taken_i = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("rst_mid");
      @(posedge clk); #1;
      chk_zero("rst_hold");
      rst = 1'b0;
      pred_valid_i = 1'b0; upd_valid_i = 1'b0;
      look(32'h80, 2'b01, 8'h20, 8'h00);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
